// File: rtl/reg_array_sweep_clear.sv
// rtl/reg_array_sweep_clear.sv - DEPTH x DSIZE register array with a handshaked sweep-clear engine
//
// Purpose: a small table/state store with one write port, one registered read port and a
// sequential clear engine that walks the array one index per cycle and zeroes each entry
// that matches a run-time selected predicate (all / stride / range / data match).
//
// Ports:
//   clock, rst_n                  clock and asynchronous active-low reset
//   wr_en, wr_addr, wr_data       write strobe, index, data; accepted only when wr_ready
//   wr_ready                      high whenever no sweep is in progress
//   rd_en, rd_addr                read strobe and index (allowed in any state)
//   rd_data, rd_vld               registered read data and its valid, one cycle after rd_en
//   clr_start                     start pulse, only honoured in IDLE
//   clr_mode, clr_arg0, clr_arg1  predicate select and its arguments
//   clr_val                       compare value for the data-match predicate
//   clr_busy, clr_done            sweep in progress / one-cycle end-of-sweep pulse
//   clr_count                     number of matches in the last sweep
module reg_array_sweep_clear #(
  parameter int DSIZE = 32,
  parameter int DEPTH = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [DSIZE-1:0] wr_data,
  output logic             wr_ready,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [DSIZE-1:0] rd_data,
  output logic             rd_vld,
  input  logic             clr_start,
  input  logic [1:0]       clr_mode,
  input  logic [AW-1:0]    clr_arg0,
  input  logic [AW-1:0]    clr_arg1,
  input  logic [DSIZE-1:0] clr_val,
  output logic             clr_busy,
  output logic             clr_done,
  output logic [AW:0]      clr_count
);

  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [AW-1:0]    arg0_q, arg0_d;
  logic [AW-1:0]    arg1_q, arg1_d;
  logic [DSIZE-1:0] val_q, val_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [AW:0]      hit_q, hit_d;
  logic [AW:0]      count_q, count_d;
  logic [DSIZE-1:0] mem_q [DEPTH];
  logic [DSIZE-1:0] rd_data_q;
  logic             rd_vld_q;

  logic start_acc;
  logic sweeping;
  logic match;
  logic wr_in_range;
  logic rd_in_range;

  assign start_acc   = (state_q == S_IDLE) && clr_start;
  assign sweeping    = (state_q == S_SWEEP);
  assign wr_in_range = ({1'b0, wr_addr} < (AW+1)'(DEPTH));
  assign rd_in_range = ({1'b0, rd_addr} < (AW+1)'(DEPTH));

  // FSM next state and status outputs
  always_comb begin
    state_d  = state_q;
    clr_busy = 1'b0;
    clr_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (clr_start) state_d = S_SWEEP;
      end
      S_SWEEP: begin
        clr_busy = 1'b1;
        if (idx_q == AW'(DEPTH-1)) state_d = S_DONE;
      end
      S_DONE: begin
        clr_done = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Predicate for the index under evaluation. Stride mode tracks the next hit index
  // in an AW+1 bit register, so once it steps past DEPTH-1 nothing can match again.
  always_comb begin
    match = 1'b0;
    case (mode_q)
      2'd0: match = 1'b1;
      2'd1: match = ({1'b0, idx_q} == hit_q);
      2'd2: match = (idx_q >= arg0_q) && (idx_q <= arg1_q);
      default: match = (mem_q[idx_q] == val_q);
    endcase
  end

  always_comb begin
    mode_d  = mode_q;
    arg0_d  = arg0_q;
    arg1_d  = arg1_q;
    val_d   = val_q;
    idx_d   = idx_q;
    hit_d   = hit_q;
    count_d = count_q;
    if (start_acc) begin
      mode_d  = clr_mode;
      arg0_d  = clr_arg0;
      arg1_d  = clr_arg1;
      val_d   = clr_val;
      idx_d   = '0;
      count_d = '0;
      hit_d   = {1'b0, clr_arg0};
    end else if (sweeping) begin
      idx_d = idx_q + AW'(1);
      if (match) begin
        count_d = count_q + (AW+1)'(1);
        if (mode_q == 2'd1) hit_d = hit_q + {1'b0, arg1_q};
      end
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mode_q  <= '0;
      arg0_q  <= '0;
      arg1_q  <= '0;
      val_q   <= '0;
      idx_q   <= '0;
      hit_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      arg0_q  <= arg0_d;
      arg1_q  <= arg1_d;
      val_q   <= val_d;
      idx_q   <= idx_d;
      hit_q   <= hit_d;
      count_q <= count_d;
    end
  end

  // Array storage and read port. Writes are blocked while sweeping, so a write and a
  // clear never target the array on the same edge. Reads sample pre-edge contents.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_data_q <= '0;
      rd_vld_q  <= 1'b0;
    end else begin
      if (wr_en && wr_ready && wr_in_range) mem_q[wr_addr] <= wr_data;
      if (sweeping && match) mem_q[idx_q] <= '0;
      if (rd_en) rd_data_q <= rd_in_range ? mem_q[rd_addr] : '0;
      rd_vld_q <= rd_en;
    end
  end

  assign wr_ready  = !clr_busy;
  assign rd_data   = rd_data_q;
  assign rd_vld    = rd_vld_q;
  assign clr_count = count_q;

endmodule

// File: tb/tb_reg_array_sweep_clear.sv
// tb/tb_reg_array_sweep_clear.sv - self-checking bench for reg_array_sweep_clear
module tb_reg_array_sweep_clear;

  localparam int DSIZE = 32;
  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic             clock = 1'b0;
  logic             rst_n;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [DSIZE-1:0] wr_data;
  logic             wr_ready;
  logic             rd_en;
  logic [AW-1:0]    rd_addr;
  logic [DSIZE-1:0] rd_data;
  logic             rd_vld;
  logic             clr_start;
  logic [1:0]       clr_mode;
  logic [AW-1:0]    clr_arg0;
  logic [AW-1:0]    clr_arg1;
  logic [DSIZE-1:0] clr_val;
  logic             clr_busy;
  logic             clr_done;
  logic [AW:0]      clr_count;

  reg_array_sweep_clear #(.DSIZE(DSIZE), .DEPTH(DEPTH)) dut (
    .clock(clock), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_vld(rd_vld),
    .clr_start(clr_start), .clr_mode(clr_mode), .clr_arg0(clr_arg0), .clr_arg1(clr_arg1),
    .clr_val(clr_val), .clr_busy(clr_busy), .clr_done(clr_done), .clr_count(clr_count)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  bit checking = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: array contents, sweep position (-1 idle, 0..DEPTH-1 sweeping,
  // DEPTH = done cycle) and the expected registered read outputs.
  logic [DSIZE-1:0] m [DEPTH];
  int               pos = -1;
  int               mcnt = 0;
  int               lm_mode, lm_a0, lm_a1;
  logic [DSIZE-1:0] lm_val;
  logic [DSIZE-1:0] e_rd_data = '0;
  logic             e_rd_vld = 1'b0;

  function automatic bit pred(input int i);
    case (lm_mode)
      0: return 1'b1;
      1: begin
        if (i < lm_a0) return 1'b0;
        if (lm_a1 == 0) return (i == lm_a0);
        return ((i - lm_a0) % lm_a1) == 0;
      end
      2: return (i >= lm_a0) && (i <= lm_a1);
      default: return m[i] == lm_val;
    endcase
  endfunction

  always @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) m[i] = '0;
      pos = -1;
      mcnt = 0;
      e_rd_data = '0;
      e_rd_vld = 1'b0;
    end else begin
      bit can_write;
      can_write = !(pos >= 0 && pos < DEPTH);
      if (rd_en) e_rd_data = (int'(rd_addr) < DEPTH) ? m[rd_addr] : '0;
      e_rd_vld = rd_en;
      if (pos == DEPTH) pos = -1;
      else if (pos >= 0) begin
        if (pred(pos)) begin
          m[pos] = '0;
          mcnt++;
        end
        pos++;
      end else if (clr_start) begin
        lm_mode = int'(clr_mode);
        lm_a0 = int'(clr_arg0);
        lm_a1 = int'(clr_arg1);
        lm_val = clr_val;
        pos = 0;
        mcnt = 0;
      end
      if (can_write && wr_en && int'(wr_addr) < DEPTH) m[wr_addr] = wr_data;
    end
  end

  always @(negedge clock) begin
    if (checking) begin
      bit e_busy;
      e_busy = (pos >= 0 && pos < DEPTH);
      check("rd_vld", rd_vld, e_rd_vld);
      check("rd_data", rd_data, e_rd_data);
      check("clr_busy", clr_busy, e_busy);
      check("clr_done", clr_done, pos == DEPTH);
      check("wr_ready", wr_ready, !e_busy);
      check("clr_count", clr_count, mcnt);
    end
  end

  task automatic write(input int a, input logic [DSIZE-1:0] d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
    @(negedge clock);
    wr_en = 1'b0;
  endtask

  task automatic rd(input int a, output logic [DSIZE-1:0] d);
    rd_en = 1'b1; rd_addr = AW'(a);
    @(negedge clock);
    rd_en = 1'b0;
    d = rd_data;
    check("rd_vld_after_read", rd_vld, 1);
  endtask

  task automatic fill();
    for (int i = 0; i < DEPTH; i++) write(i, DSIZE'(i + 1));
  endtask

  task automatic sweep(input int mode, input int a0, input int a1, input logic [DSIZE-1:0] val,
                       input bit inject, input int exp_cnt, input string tag);
    int busy_n, done_n, done_at;
    clr_start = 1'b1; clr_mode = 2'(mode); clr_arg0 = AW'(a0); clr_arg1 = AW'(a1); clr_val = val;
    @(negedge clock);
    clr_start = 1'b0;
    busy_n = 0; done_n = 0; done_at = -1;
    for (int k = 0; k < DEPTH + 4; k++) begin
      if (clr_busy) busy_n++;
      if (clr_done) begin
        done_n++;
        done_at = k;
      end
      if (inject && k == 3) begin
        check({tag, "_wr_ready_busy"}, wr_ready, 0);
        wr_en = 1'b1; wr_addr = 5; wr_data = 'h55;
      end
      if (inject && k == 8) begin
        clr_start = 1'b1; clr_mode = 2'd0;
      end
      @(negedge clock);
      wr_en = 1'b0;
      clr_start = 1'b0;
    end
    check({tag, "_busy_cycles"}, busy_n, DEPTH);
    check({tag, "_done_pulses"}, done_n, 1);
    check({tag, "_done_latency"}, done_at, DEPTH);
    check({tag, "_count"}, clr_count, exp_cnt);
  endtask

  initial begin
    logic [DSIZE-1:0] d;
    int dn;
    rst_n = 1'b1; wr_en = 0; wr_addr = 0; wr_data = 0; rd_en = 0; rd_addr = 0;
    clr_start = 0; clr_mode = 0; clr_arg0 = 0; clr_arg1 = 0; clr_val = 0;
    #1 rst_n = 1'b0;
    #2 checking = 1;
    repeat (3) @(negedge clock);
    rst_n = 1'b1;
    @(negedge clock);
    check("reset_rd_data", rd_data, 0);
    check("reset_rd_vld", rd_vld, 0);
    check("reset_busy", clr_busy, 0);
    check("reset_count", clr_count, 0);
    check("reset_wr_ready", wr_ready, 1);

    // 1: fill and read back
    fill();
    for (int i = 0; i < DEPTH; i++) begin
      rd(i, d);
      check("t1_read", d, i + 1);
    end

    // 2: clear all
    sweep(0, 0, 0, '0, 0, 32, "t2");
    for (int i = 0; i < DEPTH; i++) begin
      rd(i, d);
      check("t2_read", d, 0);
    end

    // 3: stride 2/5 then stride 2/0
    fill();
    sweep(1, 2, 5, '0, 0, 6, "t3a");
    for (int i = 0; i < DEPTH; i++) begin
      rd(i, d);
      check("t3a_read", d, (i == 2 || i == 7 || i == 12 || i == 17 || i == 22 || i == 27) ? 0 : i + 1);
    end
    fill();
    sweep(1, 2, 0, '0, 0, 1, "t3b");
    rd(2, d); check("t3b_idx2", d, 0);
    rd(7, d); check("t3b_idx7", d, 8);

    // 4: range 10..12 then inverted range
    fill();
    sweep(2, 10, 12, '0, 0, 3, "t4a");
    rd(9, d);  check("t4a_idx9", d, 10);
    rd(10, d); check("t4a_idx10", d, 0);
    rd(12, d); check("t4a_idx12", d, 0);
    rd(13, d); check("t4a_idx13", d, 14);
    sweep(2, 12, 10, '0, 0, 0, "t4b");
    rd(11, d); check("t4b_idx11", d, 0);
    rd(14, d); check("t4b_idx14", d, 15);

    // 5: data match with a dropped write and an ignored restart
    fill();
    write(3, 'hAA);
    write(30, 'hAA);
    sweep(3, 0, 0, 'hAA, 1, 2, "t5");
    rd(3, d);  check("t5_idx3", d, 0);
    rd(30, d); check("t5_idx30", d, 0);
    rd(5, d);  check("t5_idx5", d, 6);
    rd(4, d);  check("t5_idx4", d, 5);

    // 6: reset in the middle of a clear-all sweep
    fill();
    clr_start = 1'b1; clr_mode = 2'd0;
    @(negedge clock);
    clr_start = 1'b0;
    repeat (9) @(negedge clock);
    rd(31, d);
    check("t6_pre_rd", d, 32);
    check("t6_pre_count", clr_count, 10);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_rd_data", rd_data, 0);
    check("t6_rst_rd_vld", rd_vld, 0);
    check("t6_rst_busy", clr_busy, 0);
    check("t6_rst_done", clr_done, 0);
    check("t6_rst_count", clr_count, 0);
    repeat (2) @(negedge clock);
    rst_n = 1'b1;
    dn = 0;
    for (int k = 0; k < DEPTH + 4; k++) begin
      @(negedge clock);
      if (clr_done) dn++;
    end
    check("t6_no_done", dn, 0);
    check("t6_wr_ready", wr_ready, 1);
    rd(31, d); check("t6_idx31", d, 0);

    // Random traffic against the model
    for (int c = 0; c < 1500; c++) begin
      wr_en = 1'($urandom_range(0, 1));
      wr_addr = AW'($urandom_range(0, DEPTH - 1));
      wr_data = DSIZE'($urandom_range(0, 3));
      rd_en = 1'($urandom_range(0, 1));
      rd_addr = AW'($urandom_range(0, DEPTH - 1));
      clr_start = ($urandom_range(0, 29) == 0);
      clr_mode = 2'($urandom_range(0, 3));
      clr_arg0 = AW'($urandom_range(0, DEPTH - 1));
      clr_arg1 = AW'($urandom_range(0, DEPTH - 1));
      clr_val = DSIZE'($urandom_range(0, 3));
      @(negedge clock);
    end
    wr_en = 0; rd_en = 0; clr_start = 0;
    repeat (DEPTH + 4) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_array_sweep_clear.md
Name: reg_array_sweep_clear

Overview:
- Parametrised DEPTH x DSIZE register array with a single write port and a single registered read port.
- Adds a sequential clear engine that sweeps the array one index per cycle and zeroes the entries that match a selectable predicate.
- Generalises the fixed combinational index-match clear into a run-time-configurable, handshaked sweep.
- Used as a small table or state store in datapath and test infrastructure blocks.

Parameters:
DSIZE, 32, data width of each entry.
DEPTH, 32, number of entries; any value >= 2; AW = $clog2(DEPTH).

Ports:
clock  in  1  system clock
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  write strobe
wr_addr  in  AW  write index
wr_data  in  DSIZE  write data
wr_ready  out  1  write accepted when high
rd_en  in  1  read strobe
rd_addr  in  AW  read index
rd_data  out  DSIZE  read data, registered
rd_vld  out  1  rd_data valid, one cycle after rd_en
clr_start  in  1  start a clear sweep (pulse)
clr_mode  in  2  0 = all, 1 = stride, 2 = range, 3 = data match
clr_arg0  in  AW  stride start / range low
clr_arg1  in  AW  stride step / range high
clr_val  in  DSIZE  compare value for mode 3
clr_busy  out  1  sweep in progress
clr_done  out  1  one-cycle pulse at sweep end
clr_count  out  AW+1  entries cleared by the last sweep

Behaviour:
- Reset (async, rst_n low):
  - All array entries, rd_data, rd_vld, clr_busy, clr_done, clr_count and the FSM go to 0 / IDLE.
  - wr_ready = 1 after reset.
  - Reset asserted mid-sweep aborts the sweep immediately; no done pulse is produced.
- Write:
  - wr_ready = !clr_busy.
  - A write occurs on the clock edge when wr_en && wr_ready.
  - wr_en while busy is dropped; there is no queuing.
  - wr_addr >= DEPTH is dropped.
- Read:
  - Reads are allowed in any state.
  - rd_data is registered from the array contents before any same-edge write or clear (read-before-write).
  - rd_vld = rd_en delayed one cycle.
  - rd_addr >= DEPTH returns 0 with rd_vld = 1.
  - rd_data holds its value when rd_en is low.
- FSM: IDLE -> SWEEP -> DONE -> IDLE.
- IDLE:
  - clr_start = 1 latches clr_mode, clr_arg0, clr_arg1 and clr_val; index resets to 0; clr_count resets to 0; next state is SWEEP.
  - clr_busy = 1 from the next cycle.
- SWEEP:
  - Each cycle evaluates the predicate for the current index. On a match, entry[index] <= 0 and clr_count++.
  - clr_count counts matches even when the entry is already 0.
  - index increments every cycle. At index == DEPTH-1 the next state is DONE.
  - The sweep takes exactly DEPTH cycles.
  - clr_start while in SWEEP is ignored.
- DONE:
  - clr_done = 1 for exactly one cycle; clr_busy = 0 in the same cycle.
  - Next state is IDLE.
  - clr_start in DONE is ignored.
  - clr_count holds until the next accepted start.
- Predicates, evaluated on index i:
  - Mode 0: always true.
  - Mode 1 (stride): uses a hit register, initialised to arg0; match when i == hit, then hit += arg1.
    - Addition is AW+1 bits wide; once hit >= DEPTH there are no further matches.
    - arg1 == 0 matches arg0 only.
    - arg0 >= DEPTH matches nothing.
    - No divider or modulo is used.
  - Mode 2 (range): match when arg0 <= i <= arg1, unsigned; arg0 > arg1 matches nothing.
  - Mode 3 (data match): match when entry[i] == clr_val at evaluation time.
- Total start-to-done latency: clr_start at edge N -> clr_done high in cycle N+DEPTH+1.
- Implementation size target: roughly 120-400 lines of RTL.

Test Plan:
1. Reset, then write entry[i] = i+1 for i = 0..31 and read back each index -> rd_data = i+1, one cycle after rd_en, with rd_vld high.
2. Fill as in test 1. Mode 0 start -> clr_busy high for 32 cycles, clr_done once, clr_count = 32; all reads return 0.
3. Fill as in test 1. Mode 1 with arg0 = 2, arg1 = 5 -> indices 2, 7, 12, 17, 22, 27 become 0, clr_count = 6, all others unchanged. Repeat with arg1 = 0 -> only index 2 is cleared, clr_count = 1.
4. Mode 2 with arg0 = 10, arg1 = 12 -> entries 10-12 become 0, clr_count = 3. Mode 2 with arg0 = 12, arg1 = 10 -> no change, clr_count = 0.
5. Write 0xAA to indices 3 and 30, then mode 3 with clr_val = 0xAA -> both entries become 0, clr_count = 2. During that sweep, wr_en to index 5 -> wr_ready = 0 and entry[5] is unchanged. A second clr_start mid-sweep -> ignored, and done pulses exactly once.
6. Pull rst_n low at sweep cycle 10 of a mode 0 sweep -> all outputs are 0 immediately, no clr_done. After release, the FSM is in IDLE and wr_ready = 1.
